m2_clock_generator: RTL and testbench

Generates the Famicom M2 (CPU φ2) clock from `master_clock` and drives it into the cartridge-bus glue logic. The glue logic times its bus phases, `romsel` and wait states from this M2. The block gives glitch-free start and stop, a hold-in-low-phase request for aligning MCU bus accesses, one-cycle rise/fall strobes, and a wrapping M2 cycle counter for mapper-timing tests.

---
 rtl/m2_clock_generator_if.sv | 23 ++
 rtl/m2_clock_generator.sv | 126 ++++++++++++
 tb/tb_m2_clock_generator.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/m2_clock_generator_if.sv
// rtl/m2_clock_generator_if.sv - control and status bundle for the M2 clock generator
interface m2_clock_generator_if #(
  parameter int COUNT_WIDTH = 16
);
  logic                   enable;
  logic                   hold_low;
  logic                   clear_count;
  logic                   m2;
  logic                   m2_rise;
  logic                   m2_fall;
  logic [COUNT_WIDTH-1:0] cycle_count;
  logic                   running;

  modport master (
    output enable, hold_low, clear_count,
    input  m2, m2_rise, m2_fall, cycle_count, running
  );

  modport slave (
    input  enable, hold_low, clear_count,
    output m2, m2_rise, m2_fall, cycle_count, running
  );
endinterface

// File: rtl/m2_clock_generator.sv
// rtl/m2_clock_generator.sv - Famicom M2 clock generator with glitch-free start/stop and low-phase hold
module m2_clock_generator #(
  parameter int PERIOD      = 27,
  parameter int HIGH_CYCLES = 17,
  parameter int COUNT_WIDTH = 16
) (
  input logic                  master_clock,
  input logic                  reset,
  m2_clock_generator_if.slave  bus
);
  localparam int LOW_CYCLES = PERIOD - HIGH_CYCLES;
  localparam int MAX_PHASE  = (LOW_CYCLES > HIGH_CYCLES) ? LOW_CYCLES : HIGH_CYCLES;
  localparam int PW         = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;
  localparam logic [PW-1:0] LOW_LAST  = PW'(LOW_CYCLES - 1);
  localparam logic [PW-1:0] HIGH_LAST = PW'(HIGH_CYCLES - 1);

  generate
    if (HIGH_CYCLES < 1 || LOW_CYCLES < 2) begin : g_bad_config
      $error("m2_clock_generator: need HIGH_CYCLES >= 1 and PERIOD - HIGH_CYCLES >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  state_t                 r_state;
  logic [PW-1:0]          r_phase_cnt;
  logic                   r_m2;
  logic                   r_m2_rise;
  logic                   r_m2_fall;
  logic [COUNT_WIDTH-1:0] r_cycle_count;

  state_t                 w_state_nxt;
  logic [PW-1:0]          w_phase_nxt;
  logic                   w_m2_nxt;
  logic                   w_rise_nxt;
  logic                   w_fall_nxt;
  logic                   w_count_inc;
  logic [COUNT_WIDTH-1:0] w_count_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase_cnt;
    w_m2_nxt    = r_m2;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    w_count_inc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_phase_nxt = '0;
        w_m2_nxt    = 1'b0;
        if (bus.enable) begin
          w_state_nxt = ST_LOW;
        end
      end
      ST_LOW: begin
        w_m2_nxt = 1'b0;
        if (r_phase_cnt < LOW_LAST) begin
          w_phase_nxt = r_phase_cnt + PW'(1);
        end else if (!bus.enable) begin
          w_state_nxt = ST_IDLE;
          w_phase_nxt = '0;
        end else if (!bus.hold_low) begin
          w_state_nxt = ST_HIGH;
          w_phase_nxt = '0;
          w_m2_nxt    = 1'b1;
          w_rise_nxt  = 1'b1;
        end
      end
      // enable/hold_low deliberately ignored: a high phase is never cut short
      ST_HIGH: begin
        w_m2_nxt = 1'b1;
        if (r_phase_cnt < HIGH_LAST) begin
          w_phase_nxt = r_phase_cnt + PW'(1);
        end else begin
          w_state_nxt = ST_LOW;
          w_phase_nxt = '0;
          w_m2_nxt    = 1'b0;
          w_fall_nxt  = 1'b1;
          w_count_inc = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_phase_nxt = '0;
        w_m2_nxt    = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_count_nxt = r_cycle_count;
    if (bus.clear_count) begin
      w_count_nxt = '0;
    end else if (w_count_inc) begin
      w_count_nxt = r_cycle_count + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge master_clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_phase_cnt   <= '0;
      r_m2          <= 1'b0;
      r_m2_rise     <= 1'b0;
      r_m2_fall     <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_phase_cnt   <= w_phase_nxt;
      r_m2          <= w_m2_nxt;
      r_m2_rise     <= w_rise_nxt;
      r_m2_fall     <= w_fall_nxt;
      r_cycle_count <= w_count_nxt;
    end
  end

  assign bus.m2          = r_m2;
  assign bus.m2_rise     = r_m2_rise;
  assign bus.m2_fall     = r_m2_fall;
  assign bus.cycle_count = r_cycle_count;
  assign bus.running     = (r_state != ST_IDLE);
endmodule

// File: tb/tb_m2_clock_generator.sv
// tb/tb_m2_clock_generator.sv - directed bench for m2_clock_generator (27/17 narrow counter, 12/10 variant)
module tb_m2_clock_generator;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  m2_clock_generator_if #(.COUNT_WIDTH(4))  a_if ();
  m2_clock_generator_if #(.COUNT_WIDTH(16)) b_if ();

  m2_clock_generator #(.PERIOD(27), .HIGH_CYCLES(17), .COUNT_WIDTH(4)) dut_a (
    .master_clock (clk),
    .reset        (reset),
    .bus          (a_if)
  );

  m2_clock_generator #(.PERIOD(12), .HIGH_CYCLES(10), .COUNT_WIDTH(16)) dut_b (
    .master_clock (clk),
    .reset        (reset),
    .bus          (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_checks         = 0;
    n_errors         = 0;
    reset            = 1'b1;
    a_if.enable      = 1'b0;
    a_if.hold_low    = 1'b0;
    a_if.clear_count = 1'b0;
    b_if.enable      = 1'b0;
    b_if.hold_low    = 1'b0;
    b_if.clear_count = 1'b0;

    @(negedge clk);
    chk("rst_m2", a_if.m2, 0);
    chk("rst_rise", a_if.m2_rise, 0);
    chk("rst_fall", a_if.m2_fall, 0);
    chk("rst_count", a_if.cycle_count, 0);
    chk("rst_running", a_if.running, 0);
    reset = 1'b0;
    step();
    step();
    chk("idle_running", a_if.running, 0);

    // basic waveform: rise after edge 10, fall after edge 27, period 27
    a_if.enable = 1'b1;
    step();
    chk("t1_running_e0", a_if.running, 1);
    chk("t1_m2_e0", a_if.m2, 0);
    for (int e = 1; e <= 54; e++) begin
      int pos;
      step();
      pos = e % 27;
      chk($sformatf("t1_m2@%0d", e), a_if.m2, (pos >= 10) ? 1 : 0);
      chk($sformatf("t1_rise@%0d", e), a_if.m2_rise, (pos == 10) ? 1 : 0);
      chk($sformatf("t1_fall@%0d", e), a_if.m2_fall, (pos == 0) ? 1 : 0);
      chk($sformatf("t1_count@%0d", e), a_if.cycle_count, e / 27);
    end

    // enable dropped in HIGH phase 3: full high, full low, then idle
    for (int e = 55; e <= 100; e++) begin
      step();
      chk($sformatf("t2_m2@%0d", e), a_if.m2, (e >= 64 && e < 81) ? 1 : 0);
      chk($sformatf("t2_rise@%0d", e), a_if.m2_rise, (e == 64) ? 1 : 0);
      chk($sformatf("t2_fall@%0d", e), a_if.m2_fall, (e == 81) ? 1 : 0);
      chk($sformatf("t2_running@%0d", e), a_if.running, (e < 91) ? 1 : 0);
      if (e == 67) a_if.enable = 1'b0;
    end
    chk("t2_count", a_if.cycle_count, 3);

    // restart, then hold_low sampled high on edges 37..41 -> rise after edge 42
    a_if.enable = 1'b1;
    step();
    chk("t3_running_e0", a_if.running, 1);
    for (int e = 1; e <= 90; e++) begin
      logic exp_m2;
      step();
      exp_m2 = ((e >= 10 && e < 27) || (e >= 42 && e < 59) || (e >= 69 && e < 86)) ? 1'b1 : 1'b0;
      chk($sformatf("t3_m2@%0d", e), a_if.m2, exp_m2);
      chk($sformatf("t3_rise@%0d", e), a_if.m2_rise, (e == 10 || e == 42 || e == 69) ? 1 : 0);
      chk($sformatf("t3_fall@%0d", e), a_if.m2_fall, (e == 27 || e == 59 || e == 86) ? 1 : 0);
      chk($sformatf("t3_count@%0d", e), a_if.cycle_count,
          3 + ((e >= 27) ? 1 : 0) + ((e >= 59) ? 1 : 0) + ((e >= 86) ? 1 : 0));
      if (e == 36) a_if.hold_low = 1'b1;
      if (e == 41) a_if.hold_low = 1'b0;
    end

    // 4-bit counter wraps 15 -> 0; clear on a fall edge gives 0, not 1
    for (int e = 91; e <= 400; e++) begin
      step();
      if (e <= 383 && ((e - 86) % 27) == 0) begin
        int k;
        k = (e - 86) / 27;
        chk($sformatf("t4_fall@%0d", e), a_if.m2_fall, 1);
        chk($sformatf("t4_count@%0d", e), a_if.cycle_count, (k == 11) ? 0 : ((6 + k) % 16));
      end
      if (e == 382) a_if.clear_count = 1'b1;
      if (e == 383) a_if.clear_count = 1'b0;
    end
    chk("t4_m2_high_before_reset", a_if.m2, 1);

    // asynchronous reset mid-HIGH
    reset = 1'b1;
    #1;
    chk("t5_m2_async", a_if.m2, 0);
    chk("t5_rise", a_if.m2_rise, 0);
    chk("t5_fall", a_if.m2_fall, 0);
    chk("t5_count", a_if.cycle_count, 0);
    chk("t5_running", a_if.running, 0);
    step();
    step();
    reset = 1'b0;
    step();
    chk("t5_running_e0", a_if.running, 1);
    for (int e = 1; e <= 10; e++) begin
      step();
      chk($sformatf("t5_m2@%0d", e), a_if.m2, (e >= 10) ? 1 : 0);
      chk($sformatf("t5_rise@%0d", e), a_if.m2_rise, (e == 10) ? 1 : 0);
    end

    // minimum low phase: 10 high / 2 low
    b_if.enable = 1'b1;
    step();
    chk("t6_running_e0", b_if.running, 1);
    for (int e = 1; e <= 40; e++) begin
      step();
      chk($sformatf("t6_m2@%0d", e), b_if.m2, (e >= 2 && ((e - 2) % 12) < 10) ? 1 : 0);
      chk($sformatf("t6_rise@%0d", e), b_if.m2_rise, (e >= 2 && ((e - 2) % 12) == 0) ? 1 : 0);
      chk($sformatf("t6_fall@%0d", e), b_if.m2_fall, (e >= 12 && ((e - 2) % 12) == 10) ? 1 : 0);
      chk($sformatf("t6_excl@%0d", e), b_if.m2_rise & b_if.m2_fall, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
